// File: rtl/ipsxe_fft_pkg.sv
// Shared definitions for the FFT reorder-buffer controllers.
//   bank_state_e : per-bank occupancy state of a ping-pong RAM bank
//   bitrev()     : reverses the low 'width' bits of x (upper bits return 0)
package ipsxe_fft_pkg;

    localparam int unsigned BITREV_MAX_W = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] x,
        input int unsigned             width
    );
        logic [BITREV_MAX_W-1:0] sh;
        bitrev = '0;
        for (int unsigned i = 0; i < BITREV_MAX_W; i++) begin
            if (i < width) begin
                sh        = x >> (width - 1 - i);
                bitrev[i] = sh[0];
            end
        end
    endfunction

endpackage

// File: rtl/ipsxe_fft_rd_pipe_tracker.sv
// Valid/last tracker for a 2-stage RAM read pipeline (address register +
// output register) with full downstream backpressure.
//   rd_clk, rd_rst : clock, asynchronous active-high reset
//   flush          : synchronous clear of the tracked pipeline
//   can_issue      : a read address is available this cycle
//   issue_last     : the available address is the last of its frame
//   m_ready        : downstream accepts the output sample
//   adv            : pipeline advances this cycle (drives RAM clk_en / oce)
//   issue          : a read address is captured at the next edge
//   m_valid/m_last : output-stage valid and end-of-frame marker
module ipsxe_fft_rd_pipe_tracker (
    input  logic rd_clk,
    input  logic rd_rst,
    input  logic flush,
    input  logic can_issue,
    input  logic issue_last,
    input  logic m_ready,
    output logic adv,
    output logic issue,
    output logic m_valid,
    output logic m_last
);

    logic v1;
    logic v2;
    logic last1;
    logic last2;

    // The whole pipe (including the RAM stages) moves together, so a stalled
    // output stage freezes every stage behind it.
    assign adv     = ~v2 | m_ready;
    assign issue   = adv & can_issue;
    assign m_valid = v2;
    assign m_last  = v2 & last2;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
        end else if (flush) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            last1 <= 1'b0;
            last2 <= 1'b0;
        end else if (adv) begin
            v1    <= issue;
            v2    <= v1;
            last1 <= issue & issue_last;
            last2 <= last1;
        end
    end

endmodule

// File: rtl/ipsxe_fft_reorder_buf_ctrl.sv
// Ping-pong reorder-buffer controller for one simple-dual-port RAM.
// Natural-order input frames are written into alternating banks; each full
// bank is read back in bit-reversed (BITREV=1) or natural order.
//   rd_clk, rd_rst          : clock, asynchronous active-high reset
//   flush                   : synchronous clear of banks, counters, pipeline
//   s_valid/s_ready/s_data  : input sample stream
//   m_valid/m_ready/m_data  : output sample stream, m_last marks frame end
//   bank_full[1:0]          : bank holds a complete frame (FULL or DRAINING)
//   ram_wr_en/addr/data     : RAM write port, addr = {wr_bank, wr_cnt}
//   ram_rd_addr             : {rd_bank, order(rd_cnt)}
//   ram_rd_clk_en/oce       : RAM read pipeline advance enables
//   ram_rd_data             : RAM read data, passed straight to m_data
module ipsxe_fft_reorder_buf_ctrl
    import ipsxe_fft_pkg::*;
#(
    parameter int unsigned LOG2_N     = 9,
    parameter int unsigned DATA_WIDTH = 36,
    parameter bit          BITREV     = 1'b1
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [1:0]            bank_full,
    output logic                  ram_wr_en,
    output logic [LOG2_N:0]       ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [LOG2_N:0]       ram_rd_addr,
    output logic                  ram_rd_clk_en,
    output logic                  ram_rd_oce,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    bank_state_e bank_q [2];
    bank_state_e bank_d [2];

    logic [LOG2_N-1:0] wr_cnt;
    logic [LOG2_N-1:0] rd_cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic              wr_fire;
    logic              wr_last;
    logic              rd_last;
    logic              can_issue;
    logic              issue;
    logic              adv;

    logic [BITREV_MAX_W-1:0] rev_full;
    logic [LOG2_N-1:0]       rd_ord;
    logic                    unused_rev_hi;

    // ---------------- write side ----------------
    assign s_ready     = (bank_q[wr_bank] == BANK_EMPTY) || (bank_q[wr_bank] == BANK_FILLING);
    assign wr_fire     = s_valid & s_ready;
    assign wr_last     = (wr_cnt == CNT_LAST);
    assign ram_wr_en   = wr_fire;
    assign ram_wr_addr = {wr_bank, wr_cnt};
    assign ram_wr_data = s_data;

    // ---------------- read side ----------------
    assign can_issue = (bank_q[rd_bank] == BANK_FULL) || (bank_q[rd_bank] == BANK_DRAINING);
    assign rd_last   = (rd_cnt == CNT_LAST);

    always_comb begin
        rev_full = bitrev(BITREV_MAX_W'(rd_cnt), LOG2_N);
        rd_ord   = BITREV ? rev_full[LOG2_N-1:0] : rd_cnt;
    end
    assign unused_rev_hi = ^rev_full[BITREV_MAX_W-1:LOG2_N];

    assign ram_rd_addr   = {rd_bank, rd_ord};
    assign ram_rd_clk_en = adv;
    assign ram_rd_oce    = adv;
    assign m_data        = ram_rd_data;

    ipsxe_fft_rd_pipe_tracker u_rd_pipe (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .flush      (flush),
        .can_issue  (can_issue),
        .issue_last (rd_last),
        .m_ready    (m_ready),
        .adv        (adv),
        .issue      (issue),
        .m_valid    (m_valid),
        .m_last     (m_last)
    );

    // ---------------- bank state machines ----------------
    // Write and read never target the same bank in one cycle (a FULL bank is
    // not writable, a FILLING bank is not readable), so the two updates below
    // touch disjoint banks.
    always_comb begin
        for (int unsigned b = 0; b < 2; b++) begin
            bank_d[b] = bank_q[b];
            if (wr_fire && (wr_bank == 1'(b))) begin
                bank_d[b] = wr_last ? BANK_FULL : BANK_FILLING;
            end
            if (issue && (rd_bank == 1'(b))) begin
                bank_d[b] = rd_last ? BANK_EMPTY : BANK_DRAINING;
            end
            if (flush) begin
                bank_d[b] = BANK_EMPTY;
            end
        end
    end

    always_comb begin
        bank_full = '0;
        for (int unsigned b = 0; b < 2; b++) begin
            bank_full[b] = (bank_q[b] == BANK_FULL) || (bank_q[b] == BANK_DRAINING);
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            bank_q <= '{BANK_EMPTY, BANK_EMPTY};
        end else begin
            bank_q <= bank_d;
        end
    end

    // ---------------- counters ----------------
    // N is a power of two, so the all-ones count wraps to zero on increment.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else if (flush) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_last) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
                if (rd_last) begin
                    rd_bank <= ~rd_bank;
                end
            end
        end
    end

endmodule
